bin_to_bcd_seq: RTL and testbench

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

---
 rtl/bin_to_bcd_seq_pkg.sv | 13 +
 rtl/bin_to_bcd_seq_add3_corr.sv | 12 +
 rtl/bin_to_bcd_seq.sv | 67 ++++++
 tb/tb_bin_to_bcd_seq.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/bin_to_bcd_seq_pkg.sv
// bin_to_bcd_seq_pkg: shared state encoding and default sizing for the BCD converter
package bin_to_bcd_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_DIGITS = 3;

endpackage

// File: rtl/bin_to_bcd_seq_add3_corr.sv
// add3_corr: double-dabble digit correction, 5..9 become 8..12 so the next shift carries
module add3_corr (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // digits that would exceed 9 after doubling get pre-biased by 3
    always_comb begin
        dout = (din >= 4'd5) ? din + 4'd3 : din;
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential shift-and-add-3 binary to packed BCD converter
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t                      state, state_nx;
    logic [WIDTH-1:0]            bin_r;
    logic [4*DIGITS-1:0]         scr;
    logic [4*DIGITS-1:0]         corr;
    logic [CW-1:0]               cnt;
    logic [4*DIGITS+WIDTH-1:0]   sh;

    for (genvar i = 0; i < DIGITS; i++) begin : g_corr
        add3_corr u_corr (
            .din  (scr[4*i+:4]),
            .dout (corr[4*i+:4])
        );
    end

    assign sh = {corr, bin_r} << 1;

    // state, operand capture, per-cycle shift and final result latch
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bin_r   <= '0;
            scr     <= '0;
            cnt     <= '0;
            bcd_out <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                bin_r <= bin_in;
                scr   <= '0;
                cnt   <= '0;
            end else if (state == SHIFT) begin
                {scr, bin_r} <= sh;
                cnt          <= (cnt == LAST) ? cnt : cnt + 1'b1;
                if (cnt == LAST)
                    bcd_out <= sh[4*DIGITS+WIDTH-1:WIDTH];
            end
        end
    end

    // next state and status flags decoded from the current state
    always_comb begin
        state_nx = (state == IDLE)  ? (start ? SHIFT : IDLE) :
                   (state == SHIFT) ? ((cnt == LAST) ? DONE : SHIFT) : IDLE;
        busy     = (state == SHIFT);
        done     = (state == DONE);
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed vector table plus multi-cycle corner sequences
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  bin_in = 8'd0;
    logic        busy, done;
    logic [11:0] bcd_out;
    logic [3:0]  a_in;
    logic [3:0]  a_out;

    int checks = 0;
    int errors = 0;
    logic [11:0] prev = 12'h000;

    typedef struct {
        logic [7:0]  v;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[12];
    logic [3:0] corr_exp[10];

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out)
    );

    add3_corr u_a (
        .din  (a_in),
        .dout (a_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // caller is at a negedge; start is sampled on the following posedge
    task automatic convert(input logic [7:0] v, input logic [11:0] exp);
        int cyc;
        int nb;
        int hold_bad;
        int both;
        start  = 1'b1;
        bin_in = v;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        nb = 0;
        hold_bad = 0;
        both = 0;
        while (!done && cyc < 30) begin
            if (busy) nb++;
            if (bcd_out !== prev) hold_bad++;
            @(negedge clk);
            cyc++;
        end
        if (busy && done) both++;
        chk($sformatf("latency v=%0d", v), cyc, 9);
        chk($sformatf("busy_cycles v=%0d", v), nb, 8);
        chk($sformatf("bcd v=%0d", v), bcd_out, exp);
        chk($sformatf("hold v=%0d", v), hold_bad, 0);
        chk($sformatf("busy_done v=%0d", v), both, 0);
        prev = exp;
        @(negedge clk);
        chk($sformatf("done_pulse v=%0d", v), done, 0);
    endtask

    initial begin
        int cyc;
        int nd;
        vecs[0]  = '{8'd0,   12'h000};
        vecs[1]  = '{8'd255, 12'h255};
        vecs[2]  = '{8'd99,  12'h099};
        vecs[3]  = '{8'd128, 12'h128};
        vecs[4]  = '{8'd1,   12'h001};
        vecs[5]  = '{8'd9,   12'h009};
        vecs[6]  = '{8'd10,  12'h010};
        vecs[7]  = '{8'd100, 12'h100};
        vecs[8]  = '{8'd200, 12'h200};
        vecs[9]  = '{8'd173, 12'h173};
        vecs[10] = '{8'd5,   12'h005};
        vecs[11] = '{8'd59,  12'h059};
        corr_exp = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12};

        for (int i = 0; i < 10; i++) begin
            a_in = 4'(i);
            #1;
            chk($sformatf("add3_corr in=%0d", i), a_out, corr_exp[i]);
        end

        repeat (3) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset bcd", bcd_out, 0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) convert(vecs[i].v, vecs[i].exp);

        for (int v = 0; v < 256; v++)
            convert(8'(v), {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)});

        // start held high, operand changes mid-conversion
        nd = 0;
        start  = 1'b1;
        bin_in = 8'd200;
        @(negedge clk);
        bin_in = 8'd7;
        cyc = 1;
        while (!done && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        if (done) nd++;
        chk("held latency", cyc, 9);
        chk("held first bcd", bcd_out, 12'h200);
        @(negedge clk);
        chk("held idle busy", busy, 0);
        chk("held idle done", done, 0);
        @(negedge clk);
        chk("held restart busy", busy, 1);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        if (done) nd++;
        chk("held second bcd", bcd_out, 12'h007);
        repeat (6) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("held done count", nd, 2);
        prev = 12'h007;

        // start pulse during SHIFT is ignored and not queued
        convert(8'd50, 12'h050);
        start  = 1'b1;
        bin_in = 8'd61;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start  = 1'b1;
        bin_in = 8'd99;
        @(negedge clk);
        start = 1'b0;
        cyc = 5;
        while (!done && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        chk("ignore latency", cyc, 9);
        chk("ignore bcd", bcd_out, 12'h061);
        @(negedge clk);
        @(negedge clk);
        chk("ignore not queued", busy, 0);
        prev = 12'h061;

        // reset during the 4th shift aborts the conversion
        start  = 1'b1;
        bin_in = 8'd173;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        nd = 0;
        @(negedge clk);
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort bcd", bcd_out, 0);
        repeat (2) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("abort no done", nd, 0);
        prev = 12'h000;
        rst = 1'b0;
        convert(8'd42, 12'h042);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
